// File: rtl/cart_sram_backup_pkg.sv
// Shared types for the cartridge SRAM backup sequencer: FSM state encoding
// and SD sector geometry.
package cart_sram_backup_pkg;

    typedef enum logic [1:0] {
        BK_IDLE,
        BK_REQ,
        BK_XFER,
        BK_NEXT
    } cart_bk_state_t;

    localparam int SECT_BYTES = 512;

endpackage

// File: rtl/cart_sram_backup_if.sv
// Bus bundle between the backup sequencer and the mappers, SRAM and SD image
// block. The slave side is the sequencer; the master side is its environment.
interface cart_sram_backup_if #(
    parameter int SRAM_AW = 14,
    parameter int SECT_AW = 9
);
    import cart_sram_backup_pkg::*;

    logic [1:0][15:0]    size_sram;
    logic [1:0]          img_mounted;
    logic [31:0]         img_size;
    logic                save_req;
    logic                cpu_slot;
    logic                cpu_sram_cs;
    logic                cpu_sram_we;
    logic [SRAM_AW-1:0]  cpu_addr;
    logic [7:0]          cpu_din;
    logic                cpu_wait;
    logic [SRAM_AW:0]    ram_addr;
    logic [7:0]          ram_din;
    logic                ram_we;
    logic [7:0]          ram_dout;
    logic [31:0]         sd_lba;
    logic [1:0]          sd_rd;
    logic [1:0]          sd_wr;
    logic [1:0]          sd_ack;
    logic [SECT_AW-1:0]  sd_buff_addr;
    logic [7:0]          sd_buff_dout;
    logic                sd_buff_wr;
    logic [7:0]          sd_buff_din;
    logic                busy;
    logic [1:0]          dirty;

    modport slave (
        input  size_sram, img_mounted, img_size, save_req,
               cpu_slot, cpu_sram_cs, cpu_sram_we, cpu_addr, cpu_din,
               ram_dout, sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
        output cpu_wait, ram_addr, ram_din, ram_we,
               sd_lba, sd_rd, sd_wr, sd_buff_din, busy, dirty
    );

    modport master (
        output size_sram, img_mounted, img_size, save_req,
               cpu_slot, cpu_sram_cs, cpu_sram_we, cpu_addr, cpu_din,
               ram_dout, sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
        input  cpu_wait, ram_addr, ram_din, ram_we,
               sd_lba, sd_rd, sd_wr, sd_buff_din, busy, dirty
    );

endinterface

// File: rtl/cart_sram_backup.sv
// Moves battery-backed SRAM of two cartridge slots to/from the SD save image,
// one sector per handshake, while owning the SRAM port and stalling the CPU.
module cart_sram_backup
    import cart_sram_backup_pkg::*;
#(
    parameter int SRAM_AW = 14,
    parameter int SECT_AW = 9
) (
    input logic               clk,
    input logic               reset,
    cart_sram_backup_if.slave bus
);

    cart_bk_state_t r_state, w_state_nx;
    logic           r_slot, w_slot_nx;
    logic           r_load, w_load_nx;
    logic [31:0]    r_lba, w_lba_nx;
    logic [1:0]     r_pend_load, r_pend_save, r_dirty;
    logic [1:0]     w_pl_clr, w_ps_clr, w_dirty_clr;
    logic [1:0]     w_has_sram, w_load_set, w_save_set, w_dirty_set, w_slot_oh;
    logic           w_busy, w_cpu_wr, w_ack, w_last;
    logic           w_sel_vld, w_sel_slot, w_sel_load;
    logic [16:0]    w_nsect_m1;

    assign w_has_sram  = {bus.size_sram[1] != 16'd0, bus.size_sram[0] != 16'd0};
    assign w_busy      = (r_state != BK_IDLE);
    assign w_slot_oh   = {r_slot, ~r_slot};
    assign w_ack       = bus.sd_ack[r_slot];
    assign w_nsect_m1  = {bus.size_sram[r_slot], 1'b0} - 17'd1;
    assign w_last      = (r_lba == {15'd0, w_nsect_m1});
    assign w_cpu_wr    = bus.cpu_sram_cs & bus.cpu_sram_we & ~w_busy;
    assign w_dirty_set = {bus.cpu_slot, ~bus.cpu_slot} & w_has_sram & {2{w_cpu_wr}};
    assign w_load_set  = bus.img_mounted & w_has_sram & {2{bus.img_size != 32'd0}};
    // A CPU write landing with save_req is folded into the snapshot so it gets saved
    assign w_save_set  = (r_dirty | w_dirty_set) & {2{bus.save_req}};

    always_comb begin
        w_sel_vld  = 1'b1;
        w_sel_slot = 1'b0;
        w_sel_load = 1'b1;
        if (r_pend_load[0]) begin
            w_sel_slot = 1'b0;
        end else if (r_pend_load[1]) begin
            w_sel_slot = 1'b1;
        end else if (r_pend_save[0]) begin
            w_sel_load = 1'b0;
        end else if (r_pend_save[1]) begin
            w_sel_slot = 1'b1;
            w_sel_load = 1'b0;
        end else begin
            w_sel_vld  = 1'b0;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_slot_nx   = r_slot;
        w_load_nx   = r_load;
        w_lba_nx    = r_lba;
        w_pl_clr    = 2'b00;
        w_ps_clr    = 2'b00;
        w_dirty_clr = 2'b00;
        unique case (r_state)
            BK_IDLE: begin
                if (w_sel_vld) begin
                    if (w_sel_load) w_pl_clr = {w_sel_slot, ~w_sel_slot};
                    else            w_ps_clr = {w_sel_slot, ~w_sel_slot};
                    // A slot whose SRAM vanished since the request is dropped silently
                    if (w_has_sram[w_sel_slot]) begin
                        w_slot_nx  = w_sel_slot;
                        w_load_nx  = w_sel_load;
                        w_lba_nx   = 32'd0;
                        w_state_nx = BK_REQ;
                    end
                end
            end
            BK_REQ:  if (w_ack)  w_state_nx = BK_XFER;
            // Entered with ack high, so ack low here is its falling edge
            BK_XFER: if (!w_ack) w_state_nx = BK_NEXT;
            BK_NEXT: begin
                if (w_last) begin
                    w_dirty_clr = w_slot_oh;
                    w_state_nx  = BK_IDLE;
                end else begin
                    w_lba_nx    = r_lba + 32'd1;
                    w_state_nx  = BK_REQ;
                end
            end
            default: w_state_nx = BK_IDLE;
        endcase
    end

    assign bus.sd_rd       = (r_state == BK_REQ &&  r_load) ? w_slot_oh : 2'b00;
    assign bus.sd_wr       = (r_state == BK_REQ && !r_load) ? w_slot_oh : 2'b00;
    assign bus.sd_lba      = r_lba;
    assign bus.sd_buff_din = bus.ram_dout;
    assign bus.busy        = w_busy;
    assign bus.cpu_wait    = bus.cpu_sram_cs & w_busy;
    assign bus.dirty       = r_dirty;

    always_comb begin
        if (w_busy) begin
            bus.ram_addr = {r_slot, r_lba[SRAM_AW-SECT_AW-1:0], bus.sd_buff_addr};
            bus.ram_din  = bus.sd_buff_dout;
            bus.ram_we   = (r_state == BK_XFER) & r_load & bus.sd_buff_wr & w_ack;
        end else begin
            bus.ram_addr = {bus.cpu_slot, bus.cpu_addr};
            bus.ram_din  = bus.cpu_din;
            bus.ram_we   = bus.cpu_sram_cs & bus.cpu_sram_we & ~reset;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= BK_IDLE;
            r_slot      <= 1'b0;
            r_load      <= 1'b0;
            r_lba       <= 32'd0;
            r_pend_load <= 2'b00;
            r_pend_save <= 2'b00;
            r_dirty     <= 2'b00;
        end else begin
            r_state     <= w_state_nx;
            r_slot      <= w_slot_nx;
            r_load      <= w_load_nx;
            r_lba       <= w_lba_nx;
            // New requests win over the clear so a re-trigger is never lost
            r_pend_load <= (r_pend_load & ~w_pl_clr) | w_load_set;
            r_pend_save <= (r_pend_save & ~w_ps_clr) | w_save_set;
            r_dirty     <= (r_dirty & ~w_dirty_clr) | w_dirty_set;
        end
    end

endmodule
